div_nr_seq: RTL and testbench

Parametrised sequential non-restoring integer divider, the next generation of the ALU's fixed 16-bit divider. It adds a WIDTH parameter, signed and unsigned modes, a start/ready/done handshake, divide-by-zero and signed-overflow flags, and a one-cycle remainder correction step. It sits in the ALU datapath beside the multiplier and is driven by the ALU control FSM.

---
 rtl/div_nr_seq_if.sv | 26 ++
 rtl/div_nr_seq.sv | 141 ++++++++++++++
 tb/tb_div_nr_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/div_nr_seq_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// ready/done handshake and registered results out.
interface div_nr_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_nr_seq.sv
// Parametrised non-restoring integer divider, one quotient bit per cycle,
// with a final remainder correction cycle and sign fix-up of both results.
module div_nr_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    div_nr_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             qs_q, qs_d;
    logic             rs_q, rs_d;
    logic             ovp_q, ovp_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   p_sh, p_step, p_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            ovp_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            ovp_q   <= ovp_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        ovp_d   = ovp_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        sa     = bus.signed_mode & bus.dividend[WIDTH-1];
        sb     = bus.signed_mode & bus.divisor[WIDTH-1];
        mag_a  = sa ? -bus.dividend : bus.dividend;
        mag_b  = sb ? -bus.divisor : bus.divisor;
        // Shift {P,Q} left, then add or subtract D depending on the old sign of P
        p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        p_step = p_q[WIDTH] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
        p_fix  = p_q[WIDTH] ? (p_q + {1'b0, d_q}) : p_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quot_d = '1;
                        rem_d  = bus.dividend;
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        p_d     = '0;
                        q_d     = mag_a;
                        d_d     = mag_b;
                        qs_d    = sa ^ sb;
                        rs_d    = sa;
                        ovp_d   = bus.signed_mode && (bus.dividend == MIN_VAL) &&
                                  (bus.divisor == '1);
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                p_d     = p_fix;
                quot_d  = qs_q ? -q_q : q_q;
                rem_d   = rs_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
                dbz_d   = 1'b0;
                ovf_d   = ovp_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_div_nr_seq.sv
// Bench for div_nr_seq: WIDTH=16 and WIDTH=8 instances driven with directed and
// random divisions, compared against integer arithmetic on sign-extended values.
module tb_div_nr_seq;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    div_nr_seq_if #(.WIDTH(16)) i16 ();
    div_nr_seq_if #(.WIDTH(8))  i8  ();

    div_nr_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
    div_nr_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int w, input bit st, input bit sm,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 16) begin
            i16.start = st; i16.signed_mode = sm;
            i16.dividend = a[15:0]; i16.divisor = b[15:0];
        end else begin
            i8.start = st; i8.signed_mode = sm;
            i8.dividend = a[7:0]; i8.divisor = b[7:0];
        end
    endtask

    task automatic snap(input int w, output logic rdy, output logic dn,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output logic ov);
        if (w == 16) begin
            rdy = i16.ready; dn = i16.done; q = 32'(i16.quotient); r = 32'(i16.remainder);
            dz = i16.div_by_zero; ov = i16.overflow;
        end else begin
            rdy = i8.ready; dn = i8.done; q = 32'(i8.quotient); r = 32'(i8.remainder);
            dz = i8.div_by_zero; ov = i8.overflow;
        end
    endtask

    // Reference: truncating integer division on 64-bit values.
    task automatic model(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov);
        longint mask, ua, ub, as_, bs_;
        mask = (longint'(1) << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        dz = 1'b0;
        ov = 1'b0;
        if (ub == 0) begin
            q  = 32'(mask);
            r  = 32'(ua);
            dz = 1'b1;
        end else if (sm) begin
            as_ = ((ua >> (w - 1)) & 1) != 0 ? ua - (mask + 1) : ua;
            bs_ = ((ub >> (w - 1)) & 1) != 0 ? ub - (mask + 1) : ub;
            q  = 32'((as_ / bs_) & mask);
            r  = 32'((as_ % bs_) & mask);
            ov = (as_ == -((mask + 1) >> 1)) && (bs_ == -1);
        end else begin
            q = 32'(ua / ub);
            r = 32'(ua % ub);
        end
    endtask

    // Called on the negedge where start is presented (cycle 0); returns on the done negedge.
    task automatic run_op(input int w, input bit sm, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] eq, er, q, r;
        logic edz, eov, rdy, dn, dz, ov;
        int n, exp_lat;
        bit rdy_bad;
        string tag;
        model(w, sm, a, b, eq, er, edz, eov);
        exp_lat = edz ? 1 : w + 2;
        tag = $sformatf("w%0d sm%0d %0h/%0h", w, sm, a, b);
        drive(w, 1'b1, sm, a, b);
        n = 0;
        rdy_bad = 1'b0;
        dn = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) drive(w, 1'b0, 1'($urandom), $urandom, $urandom);
            if (poke && n == 5) drive(w, 1'b1, 1'($urandom), $urandom, $urandom | 1);
            if (poke && n == 6) drive(w, 1'b0, 1'($urandom), $urandom, $urandom);
            snap(w, rdy, dn, q, r, dz, ov);
            if (!edz && n <= w + 1 && rdy) rdy_bad = 1'b1;
        end while (!dn && n < 60);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " quotient"}, q, eq);
        check({tag, " remainder"}, r, er);
        check({tag, " div_by_zero"}, 32'(dz), 32'(edz));
        check({tag, " overflow"}, 32'(ov), 32'(eov));
        check({tag, " ready_at_done"}, 32'(rdy), 32'd1);
        check({tag, " ready_low_busy"}, 32'(rdy_bad), 32'd0);
    endtask

    initial begin
        logic [31:0] q, r, a, b;
        logic rdy, dn, dz, ov;
        int seen;
        total = 0;
        passed = 0;
        rst = 1'b1;
        drive(16, 1'b0, 1'b0, 0, 0);
        drive(8, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        snap(16, rdy, dn, q, r, dz, ov);
        check("reset ready", 32'(rdy), 32'd1);
        check("reset done", 32'(dn), 32'd0);
        check("reset outputs", {q[15:0], r[15:0]}, 32'd0);
        check("reset flags", 32'({dz, ov}), 32'd0);

        // Directed cases, WIDTH=16
        run_op(16, 1'b0, 100, 7, 1'b0);
        run_op(16, 1'b1, 32'hFFF9, 32'h0002, 1'b0);
        run_op(16, 1'b1, 32'h0007, 32'hFFFE, 1'b0);
        run_op(16, 1'b0, 1234, 0, 1'b0);
        run_op(16, 1'b1, 32'h8000, 32'hFFFF, 1'b0);
        run_op(16, 1'b0, 32'hFFFF, 32'h0001, 1'b0);
        run_op(16, 1'b0, 32'h0003, 32'hFFFF, 1'b0);
        run_op(16, 1'b0, 50000, 123, 1'b1);
        run_op(16, 1'b1, 32'h8000, 32'h0000, 1'b0);
        run_op(16, 1'b1, 32'h1234, 32'h0000, 1'b0);
        run_op(16, 1'b1, 32'hABCD, 32'h0017, 1'b0);
        @(negedge clk);

        // Directed cases, WIDTH=8
        run_op(8, 1'b0, 200, 3, 1'b0);
        run_op(8, 1'b1, 32'h80, 32'h03, 1'b0);
        run_op(8, 1'b1, 32'h80, 32'hFF, 1'b1);
        run_op(8, 1'b0, 32'hFF, 32'hFF, 1'b0);
        @(negedge clk);

        // Reset mid-operation abandons the division
        drive(16, 1'b1, 1'b0, 1000, 3);
        repeat (5) @(negedge clk);
        drive(16, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap(16, rdy, dn, q, r, dz, ov);
        check("midrst ready", 32'(rdy), 32'd1);
        check("midrst done", 32'(dn), 32'd0);
        check("midrst outputs", {q[15:0], r[15:0]}, 32'd0);
        check("midrst flags", 32'({dz, ov}), 32'd0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            snap(16, rdy, dn, q, r, dz, ov);
            if (dn) seen++;
        end
        check("midrst no_done", 32'(seen), 32'd0);

        // Random operations, sometimes back-to-back, sometimes with idle gaps
        for (int i = 0; i < 60; i++) begin
            int w;
            w = (i % 3 == 0) ? 8 : 16;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = (w == 16) ? 32'h8000 : 32'h80;
            case ($urandom_range(0, 9))
                0: b = 0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(w, 1'($urandom), a, b, 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
